// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
//  state_t         converter FSM states
//  ADD3_THRESH     digit value at or above which the add-3 correction applies
//  bcd_digits_for  minimum BCD digits needed to hold any WIDTH-bit unsigned value
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] ADD3_THRESH = 4'd5;

   // ceil(width * log10(2)) in integer arithmetic; 30103/100000 is close enough for width <= 32
   function automatic int unsigned bcd_digits_for(input int unsigned width);
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Start/done handshake and result bus of the binary-to-BCD converter.
//  master: drives start/bin, observes ready/done/bcd/digits/neg
//  slave : the converter side
interface bin2bcd_if #(
   parameter int unsigned WIDTH  = 15,
   parameter int unsigned DIGITS = 5
) ();

   logic                             start;
   logic [WIDTH-1:0]                 bin;
   logic                             ready;
   logic                             done;
   logic [4*DIGITS-1:0]              bcd;
   logic [$clog2(DIGITS+1)-1:0]      digits;
   logic                             neg;

   modport master (
      output start, bin,
      input  ready, done, bcd, digits, neg
   );

   modport slave (
      input  start, bin,
      output ready, done, bcd, digits, neg
   );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 correction: adds 3 when the digit is 5 or more.
//  digit  in   4  current digit
//  adj_c  out  4  corrected digit (combinational)
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adj_c
);

   assign adj_c = (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one binary bit per clock (shift-and-add-3).
//  clk  in  rising-edge clock
//  rst  in  asynchronous active-high reset
//  bus  slave modport of bin2bcd_if:
//       start/bin in, ready/done/bcd/digits/neg out (all registered)
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int unsigned WIDTH  = 15,
   parameter int unsigned DIGITS = 5,
   parameter int unsigned SIGNED = 0
) (
   input  logic      clk,
   input  logic      rst,
   bin2bcd_if.slave  bus
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned DIG_W = $clog2(DIGITS + 1);
   localparam int unsigned CNT_W = $clog2(WIDTH);

   // Elaboration-time parameter guards
   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("bin2bcd_seq: WIDTH must be in 2..32");
   end
   if (DIGITS < bcd_digits_for(WIDTH)) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS too small for WIDTH");
   end

   state_t             state;
   logic [BCD_W-1:0]   scratch;
   logic [BCD_W-1:0]   adj_c;
   logic [WIDTH-1:0]   mag;
   logic [CNT_W-1:0]   cnt;
   logic               neg_cap;

   logic               ready_r;
   logic               done_r;
   logic [BCD_W-1:0]   bcd_r;
   logic [DIG_W-1:0]   digits_r;
   logic               neg_r;

   logic [WIDTH-1:0]   mag_in_c;
   logic               neg_in_c;
   logic [DIG_W-1:0]   sig_c;
   logic               take_c;

   // Add-3 correction on every scratch digit before each shift
   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit (scratch[4*g +: 4]),
         .adj_c (adj_c[4*g +: 4])
      );
   end

   // Operand capture: negative signed inputs are converted as magnitude.
   // The most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
   always_comb begin
      mag_in_c = bus.bin;
      neg_in_c = 1'b0;
      if ((SIGNED != 0) && bus.bin[WIDTH-1]) begin
         mag_in_c = ~bus.bin + WIDTH'(1);
         neg_in_c = 1'b1;
      end
   end

   // Significant-digit count: highest nonzero digit wins, zero reads as one digit
   always_comb begin
      sig_c = DIG_W'(1);
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (scratch[4*i +: 4] != 4'd0) begin
            sig_c = DIG_W'(i + 1);
         end
      end
   end

   // A start is only honoured while ready (IDLE or DONE)
   assign take_c = bus.start && ((state == IDLE) || (state == DONE));

   // Converter FSM and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         scratch  <= '0;
         mag      <= '0;
         cnt      <= '0;
         neg_cap  <= 1'b0;
         ready_r  <= 1'b1;
         done_r   <= 1'b0;
         bcd_r    <= '0;
         digits_r <= DIG_W'(1);
         neg_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;

         case (state)
            SHIFT: begin
               scratch <= {adj_c[BCD_W-2:0], mag[WIDTH-1]};
               mag     <= {mag[WIDTH-2:0], 1'b0};
               cnt     <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  state   <= DONE;
                  ready_r <= 1'b1;
               end
            end
            DONE: begin
               done_r   <= 1'b1;
               bcd_r    <= scratch;
               digits_r <= sig_c;
               neg_r    <= neg_cap;
               state    <= IDLE;
            end
            default: ;
         endcase

         // Accepting a start overrides the DONE->IDLE move (back-to-back operation)
         if (take_c) begin
            state   <= SHIFT;
            ready_r <= 1'b0;
            mag     <= mag_in_c;
            neg_cap <= neg_in_c;
            scratch <= '0;
            cnt     <= CNT_W'(WIDTH - 1);
         end
      end
   end

   assign bus.ready  = ready_r;
   assign bus.done   = done_r;
   assign bus.bcd    = bcd_r;
   assign bus.digits = digits_r;
   assign bus.neg    = neg_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: an unsigned WIDTH=15/DIGITS=5 instance and a signed
// WIDTH=8/DIGITS=3 instance, with a per-instance expected-result queue.
module tb_bin2bcd_seq;

   typedef struct {
      logic [19:0]  bcd;
      logic [2:0]   digits;
      logic         neg;
      int unsigned  due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   exp_t        qa[$];
   exp_t        qb[$];

   bin2bcd_if #(.WIDTH(15), .DIGITS(5)) a_if ();
   bin2bcd_if #(.WIDTH(8),  .DIGITS(3)) b_if ();

   bin2bcd_seq #(.WIDTH(15), .DIGITS(5), .SIGNED(0)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] to_bcd(input int unsigned v);
      logic [19:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [2:0] ndig(input int unsigned v);
      int unsigned x;
      int unsigned n;
      x = v;
      n = 1;
      for (int i = 0; i < 10; i++) begin
         if (x >= 10) begin
            x = x / 10;
            n++;
         end
      end
      return 3'(n);
   endfunction

   function automatic exp_t model_a(input int unsigned v, input int unsigned due);
      exp_t e;
      e.bcd    = to_bcd(v);
      e.digits = ndig(v);
      e.neg    = 1'b0;
      e.due    = due;
      return e;
   endfunction

   function automatic exp_t model_b(input logic [7:0] v, input int unsigned due);
      exp_t e;
      int unsigned m;
      m = v[7] ? (256 - int'(v)) : int'(v);
      e.bcd    = to_bcd(m);
      e.digits = ndig(m);
      e.neg    = v[7];
      e.due    = due;
      return e;
   endfunction

   // Result monitors: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && a_if.done) begin
         check("a_done_expected", 32'(qa.size() != 0), 32'd1);
         if (qa.size() != 0) begin
            e = qa.pop_front();
            check("a_bcd",    32'(a_if.bcd),    32'(e.bcd));
            check("a_digits", 32'(a_if.digits), 32'(e.digits));
            check("a_neg",    32'(a_if.neg),    32'(e.neg));
            check("a_done_cycle", cyc, e.due);
         end
      end
      if (!rst && b_if.done) begin
         check("b_done_expected", 32'(qb.size() != 0), 32'd1);
         if (qb.size() != 0) begin
            e = qb.pop_front();
            check("b_bcd",    32'(b_if.bcd),    32'(e.bcd));
            check("b_digits", 32'(b_if.digits), 32'(e.digits));
            check("b_neg",    32'(b_if.neg),    32'(e.neg));
            check("b_done_cycle", cyc, e.due);
         end
      end
   end

   // Single conversion on instance A; called just after a falling edge while idle
   task automatic conv_a(input int unsigned v);
      a_if.start = 1'b1;
      a_if.bin   = 15'(v);
      qa.push_back(model_a(v, cyc + 17));
      @(negedge clk);
      a_if.start = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic conv_b(input logic [7:0] v);
      b_if.start = 1'b1;
      b_if.bin   = v;
      qb.push_back(model_b(v, cyc + 10));
      @(negedge clk);
      b_if.start = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int unsigned k;
      a_if.start = 1'b0;
      a_if.bin   = '0;
      b_if.start = 1'b0;
      b_if.bin   = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_a_ready",  32'(a_if.ready),  32'd1);
      check("rst_a_done",   32'(a_if.done),   32'd0);
      check("rst_a_bcd",    32'(a_if.bcd),    32'd0);
      check("rst_a_digits", 32'(a_if.digits), 32'd1);
      check("rst_a_neg",    32'(a_if.neg),    32'd0);
      check("rst_b_ready",  32'(b_if.ready),  32'd1);
      rst = 1'b0;
      @(negedge clk);

      // Unsigned conversions incl. zero and all-ones
      conv_a(0);
      conv_a(9999);
      check("a_bcd_held", 32'(a_if.bcd), 32'(to_bcd(9999)));
      conv_a(32767);
      conv_a(1000);

      // Signed instance: most negative, small negative, positive max, -1, zero
      conv_b(8'h80);
      conv_b(8'hF6);
      conv_b(8'h7F);
      conv_b(8'hFF);
      conv_b(8'h00);

      // Start pulsed while busy with a different operand is ignored
      a_if.start = 1'b1;
      a_if.bin   = 15'd500;
      qa.push_back(model_a(500, cyc + 17));
      @(negedge clk);
      a_if.start = 1'b0;
      repeat (4) @(negedge clk);
      check("a_ready_busy", 32'(a_if.ready), 32'd0);
      a_if.start = 1'b1;
      a_if.bin   = 15'd777;
      @(negedge clk);
      a_if.start = 1'b0;
      repeat (30) @(negedge clk);

      // Start held high: back-to-back conversions WIDTH+1 cycles apart
      k = cyc;
      a_if.start = 1'b1;
      a_if.bin   = 15'd123;
      qa.push_back(model_a(123, k + 17));
      qa.push_back(model_a(4567, k + 33));
      @(negedge clk);
      a_if.bin = 15'd4567;
      repeat (19) @(negedge clk);
      a_if.start = 1'b0;
      repeat (20) @(negedge clk);

      // Reset during SHIFT: immediate abort, no done pulse
      a_if.start = 1'b1;
      a_if.bin   = 15'd12345;
      @(negedge clk);
      a_if.start = 1'b0;
      repeat (6) @(negedge clk);
      check("mid_a_ready_busy", 32'(a_if.ready), 32'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_a_bcd",    32'(a_if.bcd),    32'd0);
      check("mid_rst_a_digits", 32'(a_if.digits), 32'd1);
      check("mid_rst_a_ready",  32'(a_if.ready),  32'd1);
      check("mid_rst_a_done",   32'(a_if.done),   32'd0);
      check("mid_rst_b_bcd",    32'(b_if.bcd),    32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      conv_a(31000);

      check("a_queue_drained", 32'(qa.size()), 32'd0);
      check("b_queue_drained", 32'(qb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
